vdp_super_res_writer: RTL and testbench

// Write-side counterpart of the super-res scan-out path (super_color / super_mid).

---
 rtl/vdp_super_res_writer_if.sv | 51 +++++
 rtl/vdp_super_res_writer.sv | 149 ++++++++++++++
 tb/tb_vdp_super_res_writer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vdp_super_res_writer_if.sv
// Bus bundle for the super-res VRAM writer: mode/config inputs, the byte
// stream from the CPU/command side and the write handshake toward the VRAM
// arbiter. With SUPER_RES_WRITER_MASK_EN defined, a per-word byte-enable
// field (vram_wr_mask) is added.
interface vdp_super_res_writer_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 17
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              vdp_super;
    logic              super_color;
    logic              super_mid;
    logic              cfg_addr_wr;
    logic [ADDR_W-1:0] cfg_addr;
    logic              pix_wr;
    logic [7:0]        pix_data;
    logic              pix_ready;
    logic              flush;
    logic              vram_wr_req;
    logic [ADDR_W-1:0] vram_wr_addr;
    logic [31:0]       vram_wr_data;
    logic              vram_wr_ack;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;
`ifdef SUPER_RES_WRITER_MASK_EN
    logic [3:0]        vram_wr_mask;
`endif

    // Source/arbiter side: drives bytes, config and acks.
    modport master (
        output vdp_super, super_color, super_mid, cfg_addr_wr, cfg_addr,
        output pix_wr, pix_data, flush, vram_wr_ack,
        input  pix_ready, vram_wr_req, vram_wr_addr, vram_wr_data,
        input  fifo_level, overflow
`ifdef SUPER_RES_WRITER_MASK_EN
        , input vram_wr_mask
`endif
    );

    // Writer side.
    modport slave (
        input  vdp_super, super_color, super_mid, cfg_addr_wr, cfg_addr,
        input  pix_wr, pix_data, flush, vram_wr_ack,
        output pix_ready, vram_wr_req, vram_wr_addr, vram_wr_data,
        output fifo_level, overflow
`ifdef SUPER_RES_WRITER_MASK_EN
        , output vram_wr_mask
`endif
    );
endinterface

// File: rtl/vdp_super_res_writer.sv
// Super-res VRAM writer: packs a byte stream into 32-bit words in scan-out
// layout (24bpp: {00,R,G,B}; 16bpp: {p0,p1}) and queues them with an
// auto-incrementing address toward the VRAM arbiter (req/ack).
// Optional feature macro: SUPER_RES_WRITER_MASK_EN (per-word byte enables).
module vdp_super_res_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 17,
    parameter int ADDR_STEP  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vdp_super_res_writer_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    // Assembler and control state
    logic [7:0]        byte_q [4];
    logic [7:0]        byte_d [4];
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mode_q, mode_d;
    logic              pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;

    // FIFO storage
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [31:0]       fifo_data_q [FIFO_DEPTH];
`ifdef SUPER_RES_WRITER_MASK_EN
    logic [3:0]        fifo_mask_q [FIFO_DEPTH];
    logic [3:0]        push_mask;
`endif

    logic              en, mode_col, req, accept, complete, space, want_flush, push, pop;
    logic [2:0]        cnt_base, cnt_new, nbytes;
    logic [ADDR_W-1:0] addr_base;
    logic [31:0]       push_data;

    assign en       = bus.vdp_super & (bus.super_color | bus.super_mid);
    assign mode_col = bus.super_color;
    assign req      = (lvl_q != '0);

    assign bus.pix_ready    = reset_n & en & (lvl_q < DEPTH_L) & ~pend_q;
    assign bus.vram_wr_req  = req;
    assign bus.vram_wr_addr = req ? fifo_addr_q[rptr_q] : '0;
    assign bus.vram_wr_data = req ? fifo_data_q[rptr_q] : '0;
    assign bus.fifo_level   = lvl_q;
    assign bus.overflow     = ovf_q;
`ifdef SUPER_RES_WRITER_MASK_EN
    assign bus.vram_wr_mask = req ? fifo_mask_q[rptr_q] : 4'b0000;
`endif

    // Next-state: address/mode overrides first, then byte capture, then push/flush/pop.
    always_comb begin
        cnt_base  = (bus.cfg_addr_wr | (mode_col != mode_q)) ? 3'd0 : cnt_q;
        addr_base = bus.cfg_addr_wr ? bus.cfg_addr : addr_q;
        nbytes    = mode_col ? 3'd3 : 3'd4;
        accept    = bus.pix_wr & bus.pix_ready;
        for (int i = 0; i < 4; i++) begin
            byte_d[i] = (cnt_base == 3'd0) ? 8'h00 : byte_q[i];
        end
        cnt_new = cnt_base;
        if (accept) begin
            byte_d[cnt_base[1:0]] = bus.pix_data;
            cnt_new = cnt_base + 3'd1;
        end
        complete   = accept & (cnt_new == nbytes);
        space      = (lvl_q < DEPTH_L);
        want_flush = (bus.flush | pend_q) & (cnt_new != 3'd0) & ~complete;
        push       = en & (complete | (want_flush & space));
        pop        = req & bus.vram_wr_ack;
        push_data  = mode_col ? {8'h00, byte_d[0], byte_d[1], byte_d[2]}
                              : {byte_d[0], byte_d[1], byte_d[2], byte_d[3]};
`ifdef SUPER_RES_WRITER_MASK_EN
        // Enables fill from the first byte lane of the layout downward.
        push_mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < cnt_new) begin
                if (mode_col) begin
                    if (i < 3) push_mask[2-i] = 1'b1;
                end else begin
                    push_mask[3-i] = 1'b1;
                end
            end
        end
`endif
        mode_d = mode_col;
        pend_d = want_flush & ~space;
        if (push) begin
            cnt_d  = 3'd0;
            addr_d = addr_base + ADDR_W'(ADDR_STEP);
        end else begin
            cnt_d  = cnt_new;
            addr_d = addr_base;
        end
        lvl_d  = lvl_q + LVL_W'(push) - LVL_W'(pop);
        wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        ovf_d  = ovf_q | (bus.pix_wr & ~bus.pix_ready);
        if (!en) begin
            cnt_d  = 3'd0;
            addr_d = '0;
            pend_d = 1'b0;
            lvl_d  = '0;
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= 3'd0;
            addr_q <= '0;
            mode_q <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
            lvl_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            lvl_q  <= lvl_d;
        end
    end

    // Datapath storage: assembler bytes and FIFO entries, no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            byte_q[i] <= byte_d[i];
        end
        if (push) begin
            fifo_addr_q[wptr_q] <= addr_base;
            fifo_data_q[wptr_q] <= push_data;
`ifdef SUPER_RES_WRITER_MASK_EN
            fifo_mask_q[wptr_q] <= push_mask;
`endif
        end
    end
endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Directed table-driven bench for vdp_super_res_writer.
module tb_vdp_super_res_writer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vdp_super_res_writer_if #(.FIFO_DEPTH(4), .ADDR_W(17)) bus ();

    vdp_super_res_writer #(.FIFO_DEPTH(4), .ADDR_W(17), .ADDR_STEP(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        string       nm;
        logic        vs, col, mid, cw;
        logic [16:0] ca;
        logic        pw;
        logic [7:0]  pd;
        logic        fl, ack;
        logic        req;
        logic [16:0] a;
        logic [31:0] d;
        logic [2:0]  lv;
        logic        rdy, ovf;
        logic [3:0]  mk;
    } vec_t;

    vec_t vecs[$];
    int n_vec = 0;
    int n_bad = 0;
    logic m_vs, m_col, m_mid;

    task automatic set_mode(input logic vs, input logic col, input logic mid);
        m_vs = vs; m_col = col; m_mid = mid;
    endtask

    task automatic add(input string nm, input logic cw, input logic [16:0] ca,
                       input logic pw, input logic [7:0] pd, input logic fl, input logic ack,
                       input logic req, input logic [16:0] a, input logic [31:0] d,
                       input logic [2:0] lv, input logic rdy, input logic ovf, input logic [3:0] mk);
        vec_t v;
        v.nm = nm; v.vs = m_vs; v.col = m_col; v.mid = m_mid; v.cw = cw; v.ca = ca;
        v.pw = pw; v.pd = pd; v.fl = fl; v.ack = ack; v.req = req; v.a = a; v.d = d;
        v.lv = lv; v.rdy = rdy; v.ovf = ovf; v.mk = mk;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic req, input logic [16:0] a,
                         input logic [31:0] d, input logic [2:0] lv, input logic rdy,
                         input logic ovf, input logic [3:0] mk);
        logic ok;
        logic [3:0] amk;
        amk = 4'b0000;
`ifdef SUPER_RES_WRITER_MASK_EN
        amk = bus.vram_wr_mask;
`else
        amk = mk;
`endif
        n_vec++;
        ok = (bus.vram_wr_req === req) && (bus.vram_wr_addr === a) && (bus.vram_wr_data === d) &&
             (bus.fifo_level === lv) && (bus.pix_ready === rdy) && (bus.overflow === ovf) && (amk === mk);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got req=%0b addr=%h data=%h lvl=%0d rdy=%0b ovf=%0b mask=%h | want req=%0b addr=%h data=%h lvl=%0d rdy=%0b ovf=%0b mask=%h",
                     nm, bus.vram_wr_req, bus.vram_wr_addr, bus.vram_wr_data, bus.fifo_level,
                     bus.pix_ready, bus.overflow, amk, req, a, d, lv, rdy, ovf, mk);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.vdp_super = v.vs; bus.super_color = v.col; bus.super_mid = v.mid;
        bus.cfg_addr_wr = v.cw; bus.cfg_addr = v.ca; bus.pix_wr = v.pw;
        bus.pix_data = v.pd; bus.flush = v.fl; bus.vram_wr_ack = v.ack;
    endtask

    initial begin
        logic [2:0] lv;
        // ---- 16bpp: basic word, ack held high, address advance ----
        set_mode(1, 0, 1);
        add("t2_cfg", 1, 17'h00100, 0, 8'h00, 0, 1, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t2_b0",  0, 0, 1, 8'h12, 0, 1, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t2_b1",  0, 0, 1, 8'h34, 0, 1, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t2_b2",  0, 0, 1, 8'h56, 0, 1, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t2_b3",  0, 0, 1, 8'h78, 0, 1, 1, 17'h00100, 32'h12345678, 1, 1, 0, 4'hF);
        add("t2_n0",  0, 0, 1, 8'hAA, 0, 1, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t2_n1",  0, 0, 1, 8'hBB, 0, 1, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t2_n2",  0, 0, 1, 8'hCC, 0, 1, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t2_n3",  0, 0, 1, 8'hDD, 0, 1, 1, 17'h00102, 32'hAABBCCDD, 1, 1, 0, 4'hF);
        add("t2_pop", 0, 0, 0, 8'h00, 0, 1, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        // ---- 24bpp: two words queued, head stable, single pop ----
        set_mode(1, 1, 0);
        add("t3_cfg", 1, 17'h00200, 0, 8'h00, 0, 0, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t3_r0",  0, 0, 1, 8'hFF, 0, 0, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t3_g0",  0, 0, 1, 8'h80, 0, 0, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t3_b0",  0, 0, 1, 8'h01, 0, 0, 1, 17'h00200, 32'h00FF8001, 1, 1, 0, 4'h7);
        add("t3_r1",  0, 0, 1, 8'hFF, 0, 0, 1, 17'h00200, 32'h00FF8001, 1, 1, 0, 4'h7);
        add("t3_g1",  0, 0, 1, 8'h80, 0, 0, 1, 17'h00200, 32'h00FF8001, 1, 1, 0, 4'h7);
        add("t3_b1",  0, 0, 1, 8'h01, 0, 0, 1, 17'h00200, 32'h00FF8001, 2, 1, 0, 4'h7);
        add("t3_hold",0, 0, 0, 8'h00, 0, 0, 1, 17'h00200, 32'h00FF8001, 2, 1, 0, 4'h7);
        add("t3_ack", 0, 0, 0, 8'h00, 0, 1, 1, 17'h00202, 32'h00FF8001, 1, 1, 0, 4'h7);
        add("t3_idle",0, 0, 0, 8'h00, 0, 0, 1, 17'h00202, 32'h00FF8001, 1, 1, 0, 4'h7);
        add("t3_drn", 0, 0, 0, 8'h00, 0, 1, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        // ---- address wrap ----
        add("t5_cfg", 1, 17'h1FFFE, 0, 8'h00, 0, 0, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t5_a0",  0, 0, 1, 8'h01, 0, 0, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t5_a1",  0, 0, 1, 8'h02, 0, 0, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        add("t5_a2",  0, 0, 1, 8'h03, 0, 0, 1, 17'h1FFFE, 32'h00010203, 1, 1, 0, 4'h7);
        add("t5_b0",  0, 0, 1, 8'h04, 0, 0, 1, 17'h1FFFE, 32'h00010203, 1, 1, 0, 4'h7);
        add("t5_b1",  0, 0, 1, 8'h05, 0, 0, 1, 17'h1FFFE, 32'h00010203, 1, 1, 0, 4'h7);
        add("t5_b2",  0, 0, 1, 8'h06, 0, 0, 1, 17'h1FFFE, 32'h00010203, 2, 1, 0, 4'h7);
        add("t5_wrap",0, 0, 0, 8'h00, 0, 1, 1, 17'h00000, 32'h00040506, 1, 1, 0, 4'h7);
        add("t5_drn", 0, 0, 0, 8'h00, 0, 1, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        // ---- fill to full, overflow on 17th byte, resume ----
        set_mode(1, 0, 1);
        add("t4_cfg", 1, 17'h00300, 0, 8'h00, 0, 0, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
        for (int k = 1; k <= 16; k++) begin
            lv = 3'(k / 4);
            if (lv == 0)
                add($sformatf("t4_byte%0d", k), 0, 0, 1, 8'(k - 1), 0, 0, 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);
            else
                add($sformatf("t4_byte%0d", k), 0, 0, 1, 8'(k - 1), 0, 0, 1, 17'h00300, 32'h00010203,
                    lv, (lv < 4), 0, 4'hF);
        end
        add("t4_drop", 0, 0, 1, 8'h10, 0, 0, 1, 17'h00300, 32'h00010203, 4, 0, 1, 4'hF);
        add("t4_res1", 0, 0, 0, 8'h00, 0, 1, 1, 17'h00302, 32'h04050607, 3, 1, 1, 4'hF);
        add("t4_sticky",0,0, 0, 8'h00, 0, 0, 1, 17'h00302, 32'h04050607, 3, 1, 1, 4'hF);
        add("t4_res2", 0, 0, 0, 8'h00, 0, 1, 1, 17'h00304, 32'h08090A0B, 2, 1, 1, 4'hF);
        add("t4_res3", 0, 0, 0, 8'h00, 0, 1, 1, 17'h00306, 32'h0C0D0E0F, 1, 1, 1, 4'hF);
        add("t4_res4", 0, 0, 0, 8'h00, 0, 1, 0, 17'h0, 32'h0, 0, 1, 1, 4'h0);
        // ---- partial flush, same-cycle corners, disable with non-empty FIFO ----
        add("t6_cfg", 1, 17'h00400, 0, 8'h00, 0, 0, 0, 17'h0, 32'h0, 0, 1, 1, 4'h0);
        add("t6_ab",  0, 0, 1, 8'hAB, 0, 0, 0, 17'h0, 32'h0, 0, 1, 1, 4'h0);
        add("t6_cd",  0, 0, 1, 8'hCD, 0, 0, 0, 17'h0, 32'h0, 0, 1, 1, 4'h0);
        add("t6_flush",0, 0, 0, 8'h00, 1, 0, 1, 17'h00400, 32'hABCD0000, 1, 1, 1, 4'hC);
        add("cw_pw",  1, 17'h00500, 1, 8'h11, 0, 0, 1, 17'h00400, 32'hABCD0000, 1, 1, 1, 4'hC);
        add("q_22",   0, 0, 1, 8'h22, 0, 0, 1, 17'h00400, 32'hABCD0000, 1, 1, 1, 4'hC);
        add("q_33",   0, 0, 1, 8'h33, 0, 0, 1, 17'h00400, 32'hABCD0000, 1, 1, 1, 4'hC);
        add("cmp_fl", 0, 0, 1, 8'h44, 1, 0, 1, 17'h00400, 32'hABCD0000, 2, 1, 1, 4'hC);
        add("fl_nop", 0, 0, 0, 8'h00, 1, 0, 1, 17'h00400, 32'hABCD0000, 2, 1, 1, 4'hC);
        add("q_pop",  0, 0, 0, 8'h00, 0, 1, 1, 17'h00500, 32'h11223344, 1, 1, 1, 4'hF);
        add("q_hold", 0, 0, 0, 8'h00, 0, 0, 1, 17'h00500, 32'h11223344, 1, 1, 1, 4'hF);
        set_mode(0, 0, 1);
        add("t6_off", 0, 0, 0, 8'h00, 0, 0, 0, 17'h0, 32'h0, 0, 0, 1, 4'h0);
        add("t6_off2",0, 0, 0, 8'h00, 0, 0, 0, 17'h0, 32'h0, 0, 0, 1, 4'h0);
        // ---- mode switch discards the partial word ----
        set_mode(1, 0, 1);
        add("ms_cfg", 1, 17'h00600, 0, 8'h00, 0, 0, 0, 17'h0, 32'h0, 0, 1, 1, 4'h0);
        add("ms_aa",  0, 0, 1, 8'hAA, 0, 0, 0, 17'h0, 32'h0, 0, 1, 1, 4'h0);
        add("ms_bb",  0, 0, 1, 8'hBB, 0, 0, 0, 17'h0, 32'h0, 0, 1, 1, 4'h0);
        set_mode(1, 1, 0);
        add("ms_c1",  0, 0, 1, 8'h01, 0, 0, 0, 17'h0, 32'h0, 0, 1, 1, 4'h0);
        add("ms_c2",  0, 0, 1, 8'h02, 0, 0, 0, 17'h0, 32'h0, 0, 1, 1, 4'h0);
        add("ms_c3",  0, 0, 1, 8'h03, 0, 0, 1, 17'h00600, 32'h00010203, 1, 1, 1, 4'h7);

        // Reset sequence
        drive('{nm: "rst", vs: 1, col: 0, mid: 1, cw: 0, ca: 0, pw: 0, pd: 0, fl: 0, ack: 0,
                req: 0, a: 0, d: 0, lv: 0, rdy: 0, ovf: 0, mk: 0});
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, 17'h0, 32'h0, 0, 0, 0, 4'h0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check(vecs[i].nm, vecs[i].req, vecs[i].a, vecs[i].d, vecs[i].lv,
                  vecs[i].rdy, vecs[i].ovf, vecs[i].mk);
        end

        // Re-reset: sticky overflow and the queued entry are cleared
        bus.pix_wr = 1'b0; bus.vram_wr_ack = 1'b0; bus.flush = 1'b0; bus.cfg_addr_wr = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rereset", 0, 17'h0, 32'h0, 0, 0, 0, 4'h0);
        reset_n = 1'b1;
        bus.super_color = 1'b0; bus.super_mid = 1'b1;
        @(posedge clk);
        #1;
        check("release", 0, 17'h0, 32'h0, 0, 1, 0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
